ahb_burst_master: RTL and testbench

- AHB-Lite master sequencer that sits directly upstream of Bridge_Top and drives its AHB slave port (Haddr, Htrans, Hwrite, Hwdata, Hreadyin).
- Turns single-command requests from the system into NONSEQ/SEQ INCR word bursts, streams write data in and read data out, and handles wait states and ERROR responses.
- Range-checks every command against the bridge's three APB windows (0x8000_0000 to 0x8BFF_FFFF) before issuing it on the bus.

---
 rtl/ahb_burst_master.sv | 173 +++++++++++++++++
 tb/tb_ahb_burst_master.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_burst_master.sv
// AHB-Lite master that expands single commands into INCR word bursts toward Bridge_Top.
// Commands outside the bridge's APB windows are rejected before anything reaches the bus.
//
// state      | meaning
// S_IDLE     | waiting for a command, bus idle, cmd_ready high
// S_CHECK    | one cycle: range/alignment check of the registered command, bus idle
// S_XFER     | pipelined address/data phases of the burst
// S_ERR_WAIT | second cycle of an ERROR response; address phase already cancelled
module ahb_burst_master #(
    parameter int unsigned MAX_LEN_W = 4,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter logic [31:0] TOP_ADDR  = 32'h8BFF_FFFC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [31:0]          cmd_addr,
    input  logic [MAX_LEN_W-1:0] cmd_len,
    input  logic [31:0]          wdata,
    output logic                 wdata_ready,
    output logic                 rdata_valid,
    output logic [31:0]          rdata,
    output logic                 rdata_last,
    output logic                 err_valid,
    output logic [31:0]          err_addr,
    output logic                 busy,
    output logic [31:0]          Haddr,
    output logic [1:0]           Htrans,
    output logic                 Hwrite,
    output logic [31:0]          Hwdata,
    output logic                 Hreadyin,
    input  logic                 Hreadyout,
    input  logic [1:0]           Hresp,
    input  logic [31:0]          Hrdata
);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [1:0] RESP_ERR  = 2'b01;

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_XFER, S_ERR_WAIT} state_t;

    state_t               state, state_nxt;
    logic [31:0]          cmd_addr_q;
    logic [MAX_LEN_W-1:0] cmd_len_q;
    logic                 cmd_write_q;
    logic [MAX_LEN_W-1:0] addr_cnt;
    logic [MAX_LEN_W-1:0] data_cnt;
    logic                 dphase_pend;
    logic [31:0]          dphase_addr;
    logic [32:0]          end_addr;
    logic                 reject;
    logic                 addr_acc;
    logic                 data_done;
    logic                 err_hit;

    // Last beat's address, computed one bit wide so a burst cannot wrap past 4 GB and look legal.
    assign end_addr = {1'b0, cmd_addr_q} + {{(31-MAX_LEN_W){1'b0}}, cmd_len_q, 2'b00};
    assign reject   = (cmd_addr_q[1:0] != 2'b00) || (cmd_addr_q < BASE_ADDR) ||
                      (end_addr > {1'b0, TOP_ADDR});

    assign cmd_ready   = (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign Hreadyin    = Hreadyout;
    assign wdata_ready = addr_acc && Hwrite;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        addr_acc  = 1'b0;
        data_done = 1'b0;
        err_hit   = 1'b0;
        case (state)
            S_IDLE:  if (cmd_valid) state_nxt = S_CHECK;
            S_CHECK: state_nxt = reject ? S_IDLE : S_XFER;
            S_XFER: begin
                addr_acc  = (Htrans != TR_IDLE) && Hreadyout;
                data_done = dphase_pend && Hreadyout;
                err_hit   = dphase_pend && !Hreadyout && (Hresp == RESP_ERR);
                if (err_hit)
                    state_nxt = S_ERR_WAIT;
                else if (data_done && (data_cnt == cmd_len_q))
                    state_nxt = S_IDLE;
            end
            S_ERR_WAIT: if (Hreadyout) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_addr_q  <= '0;
            cmd_len_q   <= '0;
            cmd_write_q <= 1'b0;
            addr_cnt    <= '0;
            data_cnt    <= '0;
            dphase_pend <= 1'b0;
            dphase_addr <= '0;
            Haddr       <= '0;
            Htrans      <= TR_IDLE;
            Hwrite      <= 1'b0;
            Hwdata      <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            rdata_last  <= 1'b0;
            err_valid   <= 1'b0;
            err_addr    <= '0;
        end else begin
            rdata_valid <= 1'b0;
            rdata_last  <= 1'b0;
            err_valid   <= 1'b0;
            case (state)
                S_IDLE: if (cmd_valid) begin
                    cmd_addr_q  <= cmd_addr;
                    cmd_len_q   <= cmd_len;
                    cmd_write_q <= cmd_write;
                end
                S_CHECK: if (reject) begin
                    err_valid <= 1'b1;
                    err_addr  <= cmd_addr_q;
                end else begin
                    Htrans      <= TR_NONSEQ;
                    Haddr       <= cmd_addr_q;
                    Hwrite      <= cmd_write_q;
                    addr_cnt    <= '0;
                    data_cnt    <= '0;
                    dphase_pend <= 1'b0;
                end
                S_XFER: if (err_hit) begin
                    Htrans <= TR_IDLE;
                end else begin
                    if (data_done) begin
                        data_cnt <= data_cnt + 1'b1;
                        if (!Hwrite) begin
                            rdata_valid <= 1'b1;
                            rdata       <= Hrdata;
                            rdata_last  <= (data_cnt == cmd_len_q);
                        end
                    end
                    if (addr_acc) begin
                        dphase_pend <= 1'b1;
                        dphase_addr <= Haddr;
                        addr_cnt    <= addr_cnt + 1'b1;
                        if (Hwrite) Hwdata <= wdata;
                        if (addr_cnt != cmd_len_q) begin
                            Haddr  <= Haddr + 32'd4;
                            // INCR bursts may not cross a 1 KB boundary; restart with NONSEQ.
                            Htrans <= (Haddr[9:0] == 10'h3FC) ? TR_NONSEQ : TR_SEQ;
                        end else begin
                            Htrans <= TR_IDLE;
                        end
                    end else if (data_done) begin
                        dphase_pend <= 1'b0;
                    end
                end
                S_ERR_WAIT: if (Hreadyout) begin
                    err_valid   <= 1'b1;
                    err_addr    <= dphase_addr;
                    dphase_pend <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_burst_master.sv
// Bench for ahb_burst_master: behavioural AHB slave with wait/ERROR injection and queue scoreboard.
module tb_ahb_burst_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_len;
    logic [31:0] wdata;
    logic        wdata_ready, rdata_valid, rdata_last, err_valid, busy;
    logic [31:0] rdata, err_addr, Haddr, Hwdata;
    logic [1:0]  Htrans;
    logic        Hwrite, Hreadyin;
    logic        Hreadyout = 1'b1;
    logic [1:0]  Hresp = 2'b00;
    logic [31:0] Hrdata = 32'h0;

    always #5 clk = ~clk;

    ahb_burst_master dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata(wdata), .wdata_ready(wdata_ready),
        .rdata_valid(rdata_valid), .rdata(rdata), .rdata_last(rdata_last),
        .err_valid(err_valid), .err_addr(err_addr), .busy(busy),
        .Haddr(Haddr), .Htrans(Htrans), .Hwrite(Hwrite), .Hwdata(Hwdata),
        .Hreadyin(Hreadyin), .Hreadyout(Hreadyout), .Hresp(Hresp), .Hrdata(Hrdata)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [34:0] addr_q[$];
    logic [31:0] wd_q[$];
    logic [32:0] rd_q[$];
    logic [31:0] err_q[$];

    logic        dp_valid = 1'b0, dp_write = 1'b0;
    logic [31:0] dp_addr = 32'h0;
    int          wait_n = 0;
    logic        stall_en = 1'b0, err_en = 1'b0;
    logic [31:0] stall_at = 32'h0, err_at = 32'h0;
    int          stall_n = 0;
    logic        prev_stall = 1'b0, prev_err = 1'b0;
    logic [31:0] prev_haddr = 32'h0;
    logic [1:0]  prev_htrans = 2'b00;
    logic        wd_take = 1'b0;
    logic [31:0] wd_cnt = 32'h0, wd_start = 32'h0, wd_base = 32'h0;

    assign wdata = wd_base ^ ((wd_cnt - wd_start) * 32'h1111_1111);

    function automatic logic [31:0] rd_pat(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Slave drives its response for the cycle just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (wd_take) wd_cnt = wd_cnt + 32'd1;
        if (!rst || !dp_valid) begin
            Hreadyout = 1'b1;
            Hresp     = 2'b00;
            Hrdata    = 32'h0;
        end else begin
            Hrdata = rd_pat(dp_addr);
            if (err_en && dp_addr == err_at) begin
                Hresp     = 2'b01;
                Hreadyout = (wait_n >= 1);
            end else if (stall_en && dp_addr == stall_at && wait_n < stall_n) begin
                Hresp     = 2'b00;
                Hreadyout = 1'b0;
            end else begin
                Hresp     = 2'b00;
                Hreadyout = 1'b1;
            end
        end
    end

    // Monitor: samples settled outputs mid-cycle, scores events, advances the slave pipeline.
    always @(negedge clk) begin
        if (!rst) begin
            dp_valid   = 1'b0;
            wait_n     = 0;
            prev_stall = 1'b0;
            prev_err   = 1'b0;
            wd_take    = 1'b0;
        end else begin
            if (prev_stall) begin
                check_val("hold_haddr", Haddr, prev_haddr);
                check_val("hold_htrans", Htrans, prev_htrans);
            end
            if (prev_err) check_val("err_cancel_htrans", Htrans, 2'b00);
            if (Htrans == 2'b01) check_val("htrans_busy", Htrans, 2'b00);
            if (Htrans != 2'b00 && Hreadyout) begin
                if (addr_q.size() == 0) check_val("unexpected_addr_phase", {Haddr, Htrans}, 0);
                else check_val("addr_phase", {Haddr, Htrans, Hwrite}, addr_q.pop_front());
            end
            if (wdata_ready) check_val("wdata_ready_qual", {Htrans != 2'b00, Hreadyout, Hwrite}, 3'b111);
            if (dp_valid && dp_write && Hreadyout && Hresp == 2'b00) begin
                if (wd_q.size() == 0) check_val("unexpected_wbeat", {1'b1, Hwdata}, 0);
                else check_val("hwdata", Hwdata, wd_q.pop_front());
            end
            if (rdata_valid) begin
                if (rd_q.size() == 0) check_val("unexpected_rdata", {rdata_valid, rdata}, 0);
                else check_val("rdata", {rdata, rdata_last}, rd_q.pop_front());
            end else if (rdata_last) begin
                check_val("rdata_last_alone", rdata_last, 1'b0);
            end
            if (err_valid) begin
                if (err_q.size() == 0) check_val("unexpected_err", {err_valid, err_addr}, 0);
                else check_val("err_addr", err_addr, err_q.pop_front());
            end
            wd_take     = wdata_ready;
            prev_stall  = (Htrans != 2'b00) && !Hreadyout && (Hresp == 2'b00);
            prev_err    = dp_valid && !Hreadyout && (Hresp == 2'b01);
            prev_haddr  = Haddr;
            prev_htrans = Htrans;
            if (!dp_valid || Hreadyout) begin
                dp_valid = (Htrans != 2'b00) && Hreadyout;
                dp_addr  = Haddr;
                dp_write = Hwrite;
                wait_n   = 0;
            end else begin
                wait_n++;
            end
        end
    end

    task automatic push_exp(input logic wr, input logic [31:0] addr, input logic [3:0] len,
                            input logic [31:0] wbase, input logic ok, input int err_beat);
        logic [31:0] a;
        logic [1:0]  tr;
        if (!ok) begin
            err_q.push_back(addr);
            return;
        end
        for (int i = 0; i <= int'(len); i++) begin
            a  = addr + 32'(4 * i);
            tr = (i == 0 || a[9:0] == 10'd0) ? 2'b10 : 2'b11;
            addr_q.push_back({a, tr, wr});
            if (i == err_beat) begin
                err_q.push_back(a);
                break;
            end
            if (wr) wd_q.push_back(wbase ^ (32'(i) * 32'h1111_1111));
            else    rd_q.push_back({rd_pat(a), i == int'(len)});
        end
    endtask

    task automatic start_cmd(input logic wr, input logic [31:0] addr, input logic [3:0] len,
                             input logic [31:0] wbase);
        @(negedge clk);
        wd_base   = wbase;
        wd_start  = wd_cnt;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_valid = 1'b1;
        check_val("cmd_ready_idle", cmd_ready, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check_val("check_cycle_bus_idle", {busy, Htrans}, 3'b100);
    endtask

    task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [3:0] len,
                           input logic [31:0] wbase, input logic ok, input int err_beat,
                           input logic [31:0] st_at, input int st_n, input logic poke);
        int n;
        err_en   = (err_beat >= 0);
        err_at   = addr + 32'(4 * err_beat);
        stall_en = (st_n > 0);
        stall_at = st_at;
        stall_n  = st_n;
        push_exp(wr, addr, len, wbase, ok, err_beat);
        start_cmd(wr, addr, len, wbase);
        @(negedge clk);
        check_val("first_htrans", Htrans, ok ? 2'b10 : 2'b00);
        n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
            if (poke && n == 2) begin
                cmd_addr  = 32'h8000_0000;
                cmd_len   = 4'd0;
                cmd_valid = 1'b1;
                check_val("cmd_ready_busy", cmd_ready, 1'b0);
            end else begin
                cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        check_val("burst_done", busy, 1'b0);
        repeat (2) @(negedge clk);
        check_val("addr_left", addr_q.size(), 0);
        check_val("wdata_left", wd_q.size(), 0);
        check_val("rdata_left", rd_q.size(), 0);
        check_val("err_left", err_q.size(), 0);
    endtask

    task automatic reset_checks();
        check_val("rst_htrans", Htrans, 2'b00);
        check_val("rst_haddr", Haddr, 32'h0);
        check_val("rst_hwrite", Hwrite, 1'b0);
        check_val("rst_hwdata", Hwdata, 32'h0);
        check_val("rst_rdata", rdata, 32'h0);
        check_val("rst_err_addr", err_addr, 32'h0);
        check_val("rst_pulses", {rdata_valid, rdata_last, err_valid, wdata_ready}, 4'b0000);
        check_val("rst_busy_ready", {busy, cmd_ready}, 2'b01);
        check_val("hreadyin_loop", Hreadyin, Hreadyout);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0;
        cmd_len   = 4'd0;
        repeat (2) @(negedge clk);
        reset_checks();
        rst = 1'b1;

        run_cmd(1'b1, 32'h8000_0010, 4'd0,  32'hDEAD_BEEF, 1'b1, -1, 32'h0, 0, 1'b0);
        run_cmd(1'b0, 32'h8400_0000, 4'd3,  32'h0,         1'b1, -1, 32'h0, 0, 1'b0);
        run_cmd(1'b0, 32'h8400_0000, 4'd3,  32'h0,         1'b1, -1, 32'h8400_0004, 2, 1'b1);
        run_cmd(1'b1, 32'h8800_03F8, 4'd3,  32'h0BAD_F00D, 1'b1, -1, 32'h0, 0, 1'b0);
        run_cmd(1'b0, 32'h8BFF_FFF8, 4'd3,  32'h0,         1'b0, -1, 32'h0, 0, 1'b0);
        run_cmd(1'b1, 32'h7FFF_FFFC, 4'd0,  32'h0,         1'b0, -1, 32'h0, 0, 1'b0);
        run_cmd(1'b0, 32'h8000_0002, 4'd0,  32'h0,         1'b0, -1, 32'h0, 0, 1'b0);
        run_cmd(1'b0, 32'h8BFF_FFF0, 4'd3,  32'h0,         1'b1, -1, 32'h0, 0, 1'b0);
        run_cmd(1'b1, 32'h8000_0000, 4'd15, 32'hCAFE_0001, 1'b1, -1, 32'h0, 0, 1'b0);
        run_cmd(1'b0, 32'h8000_0000, 4'd3,  32'h0,         1'b1, 1,  32'h0, 0, 1'b0);

        // Asynchronous reset in the middle of a write burst.
        err_en   = 1'b0;
        stall_en = 1'b0;
        push_exp(1'b1, 32'h8000_0200, 4'd7, 32'h1234_5678, 1'b1, -1);
        start_cmd(1'b1, 32'h8000_0200, 4'd7, 32'h1234_5678);
        repeat (4) @(negedge clk);
        check_val("midburst_busy", busy, 1'b1);
        #2 rst = 1'b0;
        #1 reset_checks();
        addr_q.delete();
        wd_q.delete();
        rd_q.delete();
        err_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check_val("post_rst_idle", {busy, Htrans}, 3'b000);
        run_cmd(1'b0, 32'h8800_0100, 4'd1, 32'h0, 1'b1, -1, 32'h0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
